// File: rtl/msp_periph_pkg.sv
// ---------------------------------------------------------------------------
// msp_periph_pkg
// Shared definitions for MSP430 peripheral-bus blocks:
//   - word offsets of the mailbox registers relative to the block base address
//   - state encoding of the mailbox presentation FSM
//   - helper that packs the mailbox STATUS word
// ---------------------------------------------------------------------------
package msp_periph_pkg;

  localparam logic [13:0] OFS_DATA   = 14'd0;
  localparam logic [13:0] OFS_REQ    = 14'd1;
  localparam logic [13:0] OFS_ACK    = 14'd2;
  localparam logic [13:0] OFS_STATUS = 14'd3;
  localparam logic [13:0] OFS_IEN    = 14'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_RELEASE = 2'd2
  } mbx_state_t;

  // STATUS layout: [15]=full, [14]=empty, [7:0]=FIFO occupancy
  function automatic logic [15:0] status_word(input logic full,
                                              input logic empty,
                                              input logic [7:0] count);
    status_word = {full, empty, 6'h00, count};
  endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// ---------------------------------------------------------------------------
// mailbox_fifo
// Synchronous FIFO holding stream samples until software collects them.
// Parameter FIFO_DEPTH must be a power of two >= 2; pointers wrap naturally.
// Ports:
//   mclk, puc_rst   clock, asynchronous active-high reset
//   i_push, i_data  write request / sample (ignored when full)
//   i_pop           read request (ignored when empty); o_data is the head
//   o_full, o_empty occupancy flags
//   o_count         occupancy 0..FIFO_DEPTH
//   o_head_vld      registered "was non-empty last cycle" qualifier
// ---------------------------------------------------------------------------
module mailbox_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          mclk,
  input  logic                          puc_rst,
  input  logic                          i_push,
  input  logic [15:0]                   i_data,
  input  logic                          i_pop,
  output logic [15:0]                   o_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_head_vld
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_head_vld;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full     = (r_count == CW'(FIFO_DEPTH));
  assign o_empty    = (r_count == CW'(0));
  assign o_count    = r_count;
  assign o_data     = r_mem[r_rd_ptr];
  assign o_head_vld = r_head_vld;

  // A full FIFO refuses a push even when a pop happens in the same cycle
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Sample storage; contents are don't-care until the pointers say otherwise
  always_ff @(posedge mclk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and the delayed non-empty qualifier
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head_vld <= 1'b0;
    end else begin
      // The reader only sees an entry one cycle after the count shows it,
      // which gives the two-edge push-to-present latency.
      r_head_vld <= (r_count != CW'(0));
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/msp_stream_mailbox.sv
// ---------------------------------------------------------------------------
// msp_stream_mailbox
// Hardware-to-software mailbox on the MSP430 peripheral bus. Stream samples
// are queued in a FIFO and handed to software one at a time with a two-phase
// Cout/Cin handshake where hardware initiates (Cout) and software answers (Cin).
// Optional feature macro: MSP_STREAM_MAILBOX_IRQ_EN (adds irq output and IEN).
// Ports:
//   mclk, puc_rst            clock, asynchronous active-high reset
//   per_addr/din/en/we       peripheral bus access (word address, full-word
//                            writes only), per_dout combinational read data
//   in_data/in_valid         stream sample input, in_ready = FIFO not full
//   irq (optional)           Cout & ien
// Registers (word offset from BASE_ADDR):
//   +0 DATA (ro)  +1 REQ (ro, bit0=Cout)  +2 ACK (wo, bit0=Cin)
//   +3 STATUS (ro)  +4 IEN (rw, optional)
// ---------------------------------------------------------------------------
module msp_stream_mailbox
  import msp_periph_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [13:0] BASE_ADDR  = 14'hA8
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
`ifdef MSP_STREAM_MAILBOX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  mbx_state_t    r_state;
  mbx_state_t    w_state_nxt;
  logic          r_cin;
  logic [15:0]   r_data;
  logic          w_pop;
  logic [15:0]   w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_head_vld;
  logic [13:0]   w_ofs;
  logic          w_rd;
  logic          w_wr;
  logic          w_cout;
  logic          w_unused;

  mailbox_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .i_push     (in_valid),
    .i_data     (in_data),
    .i_pop      (w_pop),
    .o_data     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_head_vld (w_head_vld)
  );

  assign in_ready = ~w_full;
  assign w_cout   = (r_state == ST_PRESENT);

  // Addresses below the base wrap to large offsets and so decode as unmapped
  assign w_ofs = per_addr - BASE_ADDR;
  assign w_rd  = per_en & (per_we == 2'b00);
  assign w_wr  = per_en & (per_we == 2'b11);

  // Only bit 0 of write data carries register content
  assign w_unused = ^per_din[15:1];

  // Presentation FSM: next state and FIFO pop
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A Cin still high from an earlier exchange blocks presentation
        if (w_head_vld && !w_empty && !r_cin) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_PRESENT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (r_cin) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_RELEASE: begin
        if (!r_cin) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RELEASE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, Cin flag and the held DATA sample
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state <= ST_IDLE;
      r_cin   <= 1'b0;
      r_data  <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr && (w_ofs == OFS_ACK)) begin
        r_cin <= per_din[0];
      end
      // DATA only changes as a sample is presented, so it is stable under REQ=1
      if (w_pop) begin
        r_data <= w_head;
      end
    end
  end

`ifdef MSP_STREAM_MAILBOX_IRQ_EN
  logic r_ien;
  logic w_ien_nxt;
  logic r_irq;

  // Next interrupt-enable value as seen after this edge
  always_comb begin
    w_ien_nxt = r_ien;
    if (w_wr && (w_ofs == OFS_IEN)) begin
      w_ien_nxt = per_din[0];
    end else begin
      w_ien_nxt = r_ien;
    end
  end

  // irq is registered from next-state values so it rises and falls with Cout
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_ien <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_ien <= w_ien_nxt;
      r_irq <= (w_state_nxt == ST_PRESENT) & w_ien_nxt;
    end
  end

  assign irq = r_irq;
`endif

  // Combinational register read mux
  always_comb begin
    per_dout = 16'h0000;
    if (w_rd) begin
      case (w_ofs)
        OFS_DATA:   per_dout = r_data;
        OFS_REQ:    per_dout = {15'h0000, w_cout};
        OFS_STATUS: per_dout = status_word(w_full, w_empty, 8'(w_count));
`ifdef MSP_STREAM_MAILBOX_IRQ_EN
        OFS_IEN:    per_dout = {15'h0000, r_ien};
`endif
        default:    per_dout = 16'h0000;
      endcase
    end else begin
      per_dout = 16'h0000;
    end
  end

endmodule

// File: tb/tb_msp_stream_mailbox.sv
// ---------------------------------------------------------------------------
// tb_msp_stream_mailbox
// Directed bench for msp_stream_mailbox: reset state, single handshake,
// FIFO fill/overflow/ordered drain, stale-Cin blocking, asynchronous reset
// mid-handshake, ignored writes, and the irq feature when
// MSP_STREAM_MAILBOX_IRQ_EN is defined. Stimulus changes on the falling edge.
// ---------------------------------------------------------------------------
module tb_msp_stream_mailbox;
  import msp_periph_pkg::*;

  localparam logic [13:0] BASE = 14'hA8;

  logic        mclk;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
`ifdef MSP_STREAM_MAILBOX_IRQ_EN
  logic        irq;
`endif

  int n_cmp;
  int n_err;

  msp_stream_mailbox #(
    .FIFO_DEPTH (8),
    .BASE_ADDR  (BASE)
  ) dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready)
`ifdef MSP_STREAM_MAILBOX_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, returning at the following falling edge
  task automatic step();
    @(posedge mclk);
    @(negedge mclk);
  endtask

  task automatic rd_reg(input logic [13:0] ofs, output logic [15:0] v);
    per_addr = BASE + ofs;
    per_we   = 2'b00;
    per_en   = 1'b1;
    #1;
    v      = per_dout;
    per_en = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [13:0] ofs, input logic [15:0] exp);
    logic [15:0] v;
    rd_reg(ofs, v);
    chk_eq(tag, v, exp);
  endtask

  task automatic wr_reg(input logic [13:0] ofs, input logic [15:0] d, input logic [1:0] we);
    per_addr = BASE + ofs;
    per_din  = d;
    per_we   = we;
    per_en   = 1'b1;
    step();
    per_en   = 1'b0;
    per_we   = 2'b00;
  endtask

  task automatic push(input logic [15:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Software driver loop: wait REQ=1, read DATA, ACK=1, wait REQ=0, ACK=0
  task automatic sw_take(input string tag, output logic [15:0] v);
    logic [15:0] r;
    int n;
    n = 0;
    rd_reg(OFS_REQ, r);
    while (r != 16'h0001 && n < 40) begin
      step();
      rd_reg(OFS_REQ, r);
      n++;
    end
    chk_eq({tag, " req_hi"}, r, 16'h0001);
    rd_reg(OFS_DATA, v);
    wr_reg(OFS_ACK, 16'h0001, 2'b11);
    n = 0;
    rd_reg(OFS_REQ, r);
    while (r != 16'h0000 && n < 40) begin
      step();
      rd_reg(OFS_REQ, r);
      n++;
    end
    chk_eq({tag, " req_lo"}, r, 16'h0000);
    wr_reg(OFS_ACK, 16'h0000, 2'b11);
  endtask

  initial begin
    logic [15:0] v;
    n_cmp    = 0;
    n_err    = 0;
    puc_rst  = 1'b1;
    per_addr = 14'h0000;
    per_din  = 16'h0000;
    per_en   = 1'b0;
    per_we   = 2'b00;
    in_data  = 16'h0000;
    in_valid = 1'b0;
    repeat (2) @(negedge mclk);
    puc_rst = 1'b0;
    step();

    // Reset state
    chk_rd("rst req", OFS_REQ, 16'h0000);
    chk_rd("rst status", OFS_STATUS, 16'h4000);
    chk_rd("rst data", OFS_DATA, 16'h0000);
    chk_eq("rst in_ready", {15'h0000, in_ready}, 16'h0001);
    step();

    // Single sample: two-edge latency then full handshake
    push(16'h1234);
    chk_rd("lat k req", OFS_REQ, 16'h0000);
    chk_rd("lat k status", OFS_STATUS, 16'h0001);
    step();
    chk_rd("lat k+1 req", OFS_REQ, 16'h0000);
    step();
    chk_rd("lat k+2 req", OFS_REQ, 16'h0001);
    chk_rd("lat k+2 data", OFS_DATA, 16'h1234);
    chk_rd("lat k+2 status", OFS_STATUS, 16'h4000);
    wr_reg(OFS_ACK, 16'h0001, 2'b11);
    chk_rd("ack1 same req", OFS_REQ, 16'h0001);
    step();
    chk_rd("ack1 next req", OFS_REQ, 16'h0000);
    wr_reg(OFS_ACK, 16'h0000, 2'b11);
    chk_rd("release data held", OFS_DATA, 16'h1234);
    step();

    // Fill the FIFO while software is stalled
    for (int i = 1; i <= 8; i++) begin
      push(16'(i));
    end
    chk_rd("fill8 status", OFS_STATUS, 16'h0007);
    chk_rd("fill8 req", OFS_REQ, 16'h0001);
    chk_rd("fill8 data", OFS_DATA, 16'h0001);
    push(16'h0009);
    chk_rd("fill9 status", OFS_STATUS, 16'h8008);
    chk_eq("full in_ready", {15'h0000, in_ready}, 16'h0000);
    in_data  = 16'h000A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_rd("overflow status", OFS_STATUS, 16'h8008);
    for (int i = 1; i <= 9; i++) begin
      sw_take($sformatf("drain%0d", i), v);
      chk_eq($sformatf("drain%0d data", i), v, 16'(i));
    end
    step();
    chk_rd("drained status", OFS_STATUS, 16'h4000);
    chk_eq("drained in_ready", {15'h0000, in_ready}, 16'h0001);

    // Stale Cin blocks presentation until cleared
    wr_reg(OFS_ACK, 16'h0001, 2'b11);
    push(16'hBEEF);
    repeat (3) step();
    chk_rd("stale req", OFS_REQ, 16'h0000);
    chk_rd("stale status", OFS_STATUS, 16'h0001);
    wr_reg(OFS_ACK, 16'h0000, 2'b11);
    chk_rd("unstale req0", OFS_REQ, 16'h0000);
    step();
    chk_rd("unstale req1", OFS_REQ, 16'h0001);
    chk_rd("unstale data", OFS_DATA, 16'hBEEF);
    wr_reg(OFS_ACK, 16'h0001, 2'b11);
    step();
    wr_reg(OFS_ACK, 16'h0000, 2'b11);
    step();

    // Asynchronous reset with one presented and three queued
    push(16'h00A1);
    push(16'h00A2);
    push(16'h00A3);
    push(16'h00A4);
    chk_rd("pre-rst req", OFS_REQ, 16'h0001);
    chk_rd("pre-rst status", OFS_STATUS, 16'h0003);
    puc_rst = 1'b1;
    chk_rd("mid-rst req", OFS_REQ, 16'h0000);
    chk_rd("mid-rst status", OFS_STATUS, 16'h4000);
    chk_rd("mid-rst data", OFS_DATA, 16'h0000);
    step();
    puc_rst = 1'b0;
    step();
    push(16'h5A5A);
    step();
    step();
    chk_rd("post-rst req", OFS_REQ, 16'h0001);
    chk_rd("post-rst data", OFS_DATA, 16'h5A5A);

    // Ignored writes: byte-enable ACK writes and writes to read-only DATA
    wr_reg(OFS_ACK, 16'h0001, 2'b01);
    step();
    chk_rd("byte01 ack req", OFS_REQ, 16'h0001);
    wr_reg(OFS_ACK, 16'h0001, 2'b10);
    step();
    chk_rd("byte10 ack req", OFS_REQ, 16'h0001);
    wr_reg(OFS_DATA, 16'hFFFF, 2'b11);
    chk_rd("ro data write", OFS_DATA, 16'h5A5A);
    chk_rd("unmapped +5", 14'd5, 16'h0000);
`ifndef MSP_STREAM_MAILBOX_IRQ_EN
    wr_reg(OFS_IEN, 16'h0001, 2'b11);
    chk_rd("unmapped ien", OFS_IEN, 16'h0000);
`endif
    wr_reg(OFS_ACK, 16'h0001, 2'b11);
    step();
    wr_reg(OFS_ACK, 16'h0000, 2'b11);
    step();

`ifdef MSP_STREAM_MAILBOX_IRQ_EN
    // Interrupt follows Cout when enabled
    chk_eq("irq idle", {15'h0000, irq}, 16'h0000);
    wr_reg(OFS_IEN, 16'h0001, 2'b11);
    chk_rd("ien rd", OFS_IEN, 16'h0001);
    push(16'h1111);
    step();
    step();
    chk_rd("irq en req", OFS_REQ, 16'h0001);
    chk_eq("irq en irq", {15'h0000, irq}, 16'h0001);
    wr_reg(OFS_ACK, 16'h0001, 2'b11);
    step();
    chk_eq("irq after ack", {15'h0000, irq}, 16'h0000);
    wr_reg(OFS_ACK, 16'h0000, 2'b11);
    step();
    wr_reg(OFS_IEN, 16'h0000, 2'b11);
    push(16'h2222);
    step();
    step();
    chk_rd("irq dis req", OFS_REQ, 16'h0001);
    chk_eq("irq dis irq", {15'h0000, irq}, 16'h0000);
    sw_take("irq dis take", v);
    chk_eq("irq dis data", v, 16'h2222);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
